// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-entry controller: FSM state encoding,
// debug cause codes and the cause priority encoder.
package dbg_pkg;

  // Controller states. The core is in debug mode only in ST_DEBUG.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STEPPING   = 2'd1,
    ST_ENTRY_PEND = 2'd2,
    ST_DEBUG      = 2'd3
  } dbg_state_e;

  // dcsr.cause encodings.
  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK = 3'd1;
  localparam logic [2:0] CAUSE_TRIG   = 3'd2;
  localparam logic [2:0] CAUSE_IRQ    = 3'd3;
  localparam logic [2:0] CAUSE_STEP   = 3'd4;
  localparam logic [2:0] CAUSE_HALT   = 3'd5;

  // Priority encoder for the live causes seen in RUN/STEPPING.
  // A pending step is latched by the FSM and presented from ENTRY_PEND,
  // so it always outranks everything here.
  function automatic logic [2:0] sel_cause(input logic trig,
                                           input logic ebreak,
                                           input logic irq,
                                           input logic halt);
    logic [2:0] cause;
    cause = CAUSE_NONE;
    if (trig)        cause = CAUSE_TRIG;
    else if (ebreak) cause = CAUSE_EBREAK;
    else if (irq)    cause = CAUSE_IRQ;
    else if (halt)   cause = CAUSE_HALT;
    return cause;
  endfunction

endpackage

// File: rtl/dbg_step_cnt.sv
// Single-step instruction counter: loads the number of instructions to run
// before re-entering debug, counts committed instructions down, and flags
// the last one.
module dbg_step_cnt #(
  parameter int STEP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [STEP_CNT_W-1:0] i_load_num,
  input  logic                  i_dec,
  output logic [STEP_CNT_W-1:0] o_remain,
  output logic                  o_last
);

  logic [STEP_CNT_W-1:0] r_remain;
  logic [STEP_CNT_W-1:0] w_load_val;

  // A requested step count of zero still executes one instruction.
  assign w_load_val = (i_load_num == '0) ? STEP_CNT_W'(1) : i_load_num;

  // Load has priority over decrement; the count saturates at zero and
  // holds whenever neither load nor decrement is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remain <= '0;
    end else if (i_load) begin
      r_remain <= w_load_val;
    end else if (i_dec && (r_remain != '0)) begin
      r_remain <= r_remain - STEP_CNT_W'(1);
    end
  end

  assign o_remain = r_remain;
  assign o_last   = (r_remain == STEP_CNT_W'(1));

endmodule

// File: rtl/dbg_entry_ctrl.sv
// Debug-entry controller: arbitrates debug causes (trigger, ebreak,
// interrupt, halt, step, halt-on-reset), tracks debug mode and drives the
// single-step sequence through the dbg_step_cnt counter.
module dbg_entry_ctrl
  import dbg_pkg::*;
#(
  parameter int NUM_TRIG   = 4,
  parameter int STEP_CNT_W = 8,
  parameter int TIDX_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_ebreakm_flush_req,
  input  logic [NUM_TRIG-1:0]   alu_trig_hit,
  input  logic [NUM_TRIG-1:0]   trig_en,
  input  logic                  dbg_irq_r,
  input  logic                  dbg_halt_r,
  input  logic                  dbg_step_r,
  input  logic [STEP_CNT_W-1:0] dbg_step_num,
  input  logic                  dbg_haltreset,
  input  logic                  cmt_ena,
  input  logic                  dbg_entry_taken_ena,
  input  logic                  dbg_exit_ena,
  output logic                  dbg_mode,
  output logic                  dbg_entry_req,
  output logic                  nonalu_dbg_entry_req,
  output logic [2:0]            dbg_cause,
  output logic [TIDX_W-1:0]     dbg_trig_idx,
  output logic [2:0]            dcsr_cause,
  output logic [STEP_CNT_W-1:0] step_remain
);

  dbg_state_e r_state;
  logic       r_dbg_mode;
  logic [2:0] r_pend_cause;
  logic [2:0] r_dcsr_cause;
  logic       r_first;

  logic [NUM_TRIG-1:0] w_trig_eff;
  logic                w_trig_any;
  logic [TIDX_W-1:0]   w_trig_idx;
  logic                w_halt_eff;
  logic [2:0]          w_cause;
  logic                w_entry_req;
  logic                w_nonalu_req;
  logic                w_step_load;
  logic                w_step_dec;
  logic                w_step_last;
  logic [STEP_CNT_W-1:0] w_step_remain;

  // Only enabled trigger channels count, and halt is held off while
  // single-stepping so the step completes before a halt is honoured.
  assign w_trig_eff = alu_trig_hit & trig_en;
  assign w_trig_any = |w_trig_eff;
  assign w_halt_eff = dbg_halt_r & ~dbg_step_r;

  // Lowest-index enabled trigger wins; index reads zero when nothing fired.
  always_comb begin
    w_trig_idx = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (w_trig_eff[i]) w_trig_idx = TIDX_W'(i);
    end
  end

  // Request/cause presented to the core. Live causes are arbitrated while
  // running or stepping, a latched cause is held while an entry is
  // pending, and nothing is requested while already in debug mode.
  always_comb begin
    w_cause      = CAUSE_NONE;
    w_entry_req  = 1'b0;
    w_nonalu_req = 1'b0;
    unique case (r_state)
      ST_RUN, ST_STEPPING: begin
        w_cause      = sel_cause(w_trig_any, alu_ebreakm_flush_req,
                                 dbg_irq_r, w_halt_eff);
        w_entry_req  = (w_cause != CAUSE_NONE);
        w_nonalu_req = (sel_cause(1'b0, 1'b0, dbg_irq_r, w_halt_eff)
                        != CAUSE_NONE);
      end
      ST_ENTRY_PEND: begin
        w_cause      = r_pend_cause;
        w_entry_req  = 1'b1;
        w_nonalu_req = 1'b1;
      end
      default: begin
        w_cause      = CAUSE_NONE;
        w_entry_req  = 1'b0;
        w_nonalu_req = 1'b0;
      end
    endcase
  end

  // The step counter loads on dret when stepping is enabled and counts
  // commits only while stepping, so it holds its value everywhere else.
  assign w_step_load = (r_state == ST_DEBUG) && dbg_exit_ena && dbg_step_r;
  assign w_step_dec  = (r_state == ST_STEPPING) && cmt_ena;

  dbg_step_cnt #(
    .STEP_CNT_W (STEP_CNT_W)
  ) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_step_load),
    .i_load_num (dbg_step_num),
    .i_dec      (w_step_dec),
    .o_remain   (w_step_remain),
    .o_last     (w_step_last)
  );

  // Main debug FSM with registered debug-mode flag and dcsr cause. A taken
  // entry always beats a finishing step, so a coincident final commit does
  // not leave a step entry pending behind the debug session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_dbg_mode   <= 1'b0;
      r_pend_cause <= CAUSE_NONE;
      r_dcsr_cause <= CAUSE_NONE;
      r_first      <= 1'b1;
    end else begin
      r_first <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (dbg_entry_taken_ena && w_entry_req) begin
            r_state      <= ST_DEBUG;
            r_dbg_mode   <= 1'b1;
            r_dcsr_cause <= w_cause;
          end else if (r_first && dbg_haltreset) begin
            r_state      <= ST_ENTRY_PEND;
            r_pend_cause <= CAUSE_HALT;
          end
        end
        ST_STEPPING: begin
          if (dbg_entry_taken_ena && w_entry_req) begin
            r_state      <= ST_DEBUG;
            r_dbg_mode   <= 1'b1;
            r_dcsr_cause <= w_cause;
          end else if (cmt_ena && w_step_last) begin
            r_state      <= ST_ENTRY_PEND;
            r_pend_cause <= CAUSE_STEP;
          end
        end
        ST_ENTRY_PEND: begin
          if (dbg_entry_taken_ena) begin
            r_state      <= ST_DEBUG;
            r_dbg_mode   <= 1'b1;
            r_dcsr_cause <= r_pend_cause;
          end
        end
        ST_DEBUG: begin
          if (dbg_exit_ena) begin
            r_dbg_mode <= 1'b0;
            r_state    <= dbg_step_r ? ST_STEPPING : ST_RUN;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_dbg_mode <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_mode             = r_dbg_mode;
  assign dbg_entry_req        = w_entry_req;
  assign nonalu_dbg_entry_req = w_nonalu_req;
  assign dbg_cause            = w_cause;
  assign dbg_trig_idx         = w_trig_idx;
  assign dcsr_cause           = r_dcsr_cause;
  assign step_remain          = w_step_remain;

endmodule

// File: doc/dbg_entry_ctrl.md
DBG_ENTRY_CTRL -- requirements
Module: dbg_entry_ctrl

Interface
REQ-001 SHALL have parameter NUM_TRIG, 4, number of hardware trigger channels (1..16).
REQ-002 SHALL have parameter STEP_CNT_W, 8, width of the multi-step instruction counter.
REQ-003 SHALL have parameter TIDX_W, clog2(NUM_TRIG) (min 1), width of the trigger index.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- alu_ebreakm_flush_req  in  1  committing ebreak in M-mode targets debug.
- alu_trig_hit  in  NUM_TRIG  per-channel trigger match on the committing instruction.
- trig_en  in  NUM_TRIG  per-channel trigger enable.
- dbg_irq_r  in  1  debug interrupt.
- dbg_halt_r  in  1  halt request.
- dbg_step_r  in  1  dcsr.step.
- dbg_step_num  in  STEP_CNT_W  instructions per step; 0 treated as 1.
- dbg_haltreset  in  1  enter debug after reset release.
- cmt_ena  in  1  instruction committed this cycle.
- dbg_entry_taken_ena  in  1  core accepted debug entry this cycle.
- dbg_exit_ena  in  1  dret committed this cycle.
- dbg_mode  out  1  core in debug mode.
- dbg_entry_req  out  1  debug entry requested.
- nonalu_dbg_entry_req  out  1  entry request excluding trigger and ebreak causes.
- dbg_cause  out  3  cause of the current request.
- dbg_trig_idx  out  TIDX_W  winning trigger channel.
- dcsr_cause  out  3  registered cause of the last taken entry.
- step_remain  out  STEP_CNT_W  remaining instructions in the current step.

Function
REQ-005 SHALL implement FSM states RUN, STEPPING, ENTRY_PEND and DEBUG; dbg_mode SHALL be 1 only in DEBUG.
REQ-006 Cause codes SHALL be: ebreak 1, trigger 2, irq 3, step 4, halt 5, with priority step-pending > trigger > ebreak > irq > halt.
REQ-007 The effective trigger hit SHALL be alu_trig_hit & trig_en; the lowest-index active channel SHALL win and drive dbg_trig_idx (0 when none).
REQ-008 Halt SHALL be masked while dbg_step_r=1, unless the FSM is in DEBUG.
REQ-009 In RUN/STEPPING, dbg_entry_req SHALL be combinational OR of any unmasked cause; in ENTRY_PEND it SHALL be 1; in DEBUG it SHALL be 0.
REQ-010 nonalu_dbg_entry_req SHALL equal dbg_entry_req computed with trigger and ebreak forced to 0.
REQ-011 In DEBUG: dbg_exit_ena SHALL go to STEPPING, loading step_remain=max(dbg_step_num,1), if dbg_step_r=1; otherwise it SHALL go to RUN.
REQ-012 In STEPPING, each cmt_ena SHALL decrement step_remain; cmt_ena with step_remain=1 SHALL go to ENTRY_PEND, latching cause 4.
REQ-013 In RUN/STEPPING, dbg_entry_taken_ena with dbg_entry_req=1 SHALL go to DEBUG, and dcsr_cause SHALL be loaded with dbg_cause the same edge.
REQ-014 In ENTRY_PEND, the latched cause SHALL be held on dbg_cause until dbg_entry_taken_ena, which SHALL go to DEBUG and load dcsr_cause.
REQ-015 When the final-step cmt_ena and dbg_entry_taken_ena coincide, the taken entry SHALL win with the cause presented that cycle, and no step SHALL be left pending.
REQ-016 dbg_exit_ena outside DEBUG, and dbg_entry_taken_ena with dbg_entry_req=0, SHALL be ignored.
REQ-017 step_remain SHALL hold its value outside STEPPING and SHALL never decrement below 0.

Reset
REQ-018 rst SHALL asynchronously force: state RUN, dbg_mode 0, dcsr_cause 0, step_remain 0, and first-cycle flag 1.
REQ-019 On the first cycle after release, if dbg_haltreset=1 the FSM SHALL go to ENTRY_PEND with cause 5; the flag SHALL then clear.
REQ-020 rst asserted mid-step or mid-ENTRY_PEND SHALL discard all pending state.

Structure
REQ-021 FSM state encoding and the cause codes SHALL live in shared package dbg_pkg.
REQ-022 The step counter (load, decrement, done) SHALL be sub-module dbg_step_cnt; all other logic SHALL be in dbg_entry_ctrl.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Release rst with dbg_haltreset=1 -> next cycle ENTRY_PEND, dbg_entry_req=1, dbg_cause=5; on taken -> dbg_mode=1, dcsr_cause=5.
- In DEBUG, dbg_step_r=1, dbg_step_num=3, exit -> step_remain=3; 3 cmt_ena -> dbg_entry_req=1, cause=4; taken -> dcsr_cause=4.
- In RUN, trig_en=4'b1010 and alu_trig_hit=4'b1110, with ebreak and irq also high -> dbg_cause=2, dbg_trig_idx=1, nonalu_dbg_entry_req=1 (irq).
- In STEPPING with step_remain=1, cmt_ena, dbg_entry_taken_ena and dbg_irq_r all high -> DEBUG, dcsr_cause=3, no residual request after exit.
- In DEBUG, dbg_halt_r=1 and dbg_irq_r=1 -> dbg_entry_req=0; dbg_step_num=0 with step set -> step_remain=1 after exit.
- Assert rst during STEPPING with step_remain=5 -> step_remain=0, RUN, dbg_entry_req=0.
